// File: rtl/decode_stage.sv
// decode_stage: handshaked MIPS-style instruction decode stage.
// Splits a 32-bit instruction into register addresses, opcode/funct, shift
// amount, immediate and jump target, and adds the extended immediate,
// instruction class and write-back target. All decoded outputs come from the
// registered main entry; an optional skid entry makes in_ready a register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush, beats every transfer that cycle
//   in_valid/in_ready     upstream handshake; in_ins, in_pc payload
//   out_valid/out_ready   downstream handshake
//   op, rs_addr, rt_addr, rd_addr, shamt, aluop, imm_ext, addr, pc,
//   ins_class, wb_en, wb_addr   decoded fields of the main entry
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINK_REG   = 31,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_ins,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            op,
  output logic [4:0]            rs_addr,
  output logic [4:0]            rt_addr,
  output logic [4:0]            rd_addr,
  output logic [4:0]            shamt,
  output logic [5:0]            aluop,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [25:0]           addr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [1:0]            ins_class,
  output logic                  wb_en,
  output logic [4:0]            wb_addr
);

  localparam int unsigned DW = DATA_WIDTH;

  typedef struct packed {
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    aluop;
    logic [DW-1:0] imm_ext;
    logic [25:0]   addr;
    logic [DW-1:0] pc;
    logic [1:0]    cls;
    logic          wb_en;
    logic [4:0]    wb_addr;
  } dec_t;

  dec_t        dec_c;
  dec_t        m_q;
  dec_t        s_q;
  logic        m_valid;
  logic        s_valid;
  logic        in_xfer;
  logic        out_xfer;
  logic [5:0]  op_c;
  logic [5:0]  fn_c;
  logic [15:0] imm_c;

  assign op_c  = in_ins[31:26];
  assign fn_c  = in_ins[5:0];
  assign imm_c = in_ins[15:0];

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec_c         = '0;
    dec_c.op      = op_c;
    dec_c.rs      = in_ins[25:21];
    dec_c.rt      = in_ins[20:16];
    dec_c.rd      = in_ins[15:11];
    dec_c.shamt   = in_ins[10:6];
    dec_c.aluop   = fn_c;
    dec_c.addr    = in_ins[25:0];
    dec_c.pc      = in_pc;

    // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
    case (op_c)
      6'h0C, 6'h0D, 6'h0E: dec_c.imm_ext = DW'(imm_c);
      6'h0F:               dec_c.imm_ext = DW'({imm_c, 16'h0000});
      default:             dec_c.imm_ext = DW'($signed(imm_c));
    endcase

    case (op_c)
      6'h00: begin
        dec_c.cls     = 2'd0;
        dec_c.wb_en   = (fn_c != 6'h08);
        dec_c.wb_addr = in_ins[15:11];
      end
      6'h02: dec_c.cls = 2'd2;
      6'h03: begin
        dec_c.cls     = 2'd2;
        dec_c.wb_en   = 1'b1;
        dec_c.wb_addr = 5'(LINK_REG);
      end
      6'h04, 6'h05, 6'h28, 6'h2B: dec_c.cls = 2'd1;
      default: begin
        dec_c.cls     = 2'd1;
        dec_c.wb_en   = 1'b1;
        dec_c.wb_addr = in_ins[20:16];
      end
    endcase

    if (!dec_c.wb_en) dec_c.wb_addr = '0;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = m_valid && out_ready;

  // With a skid entry in_ready is just the registered S-empty flag.
  assign in_ready = (SKID != 0) ? !s_valid : (!m_valid || out_ready);

  // Main/skid entry storage; flush wins over every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (SKID != 0) begin
      // in_xfer cannot coincide with a full S, so S->M needs no input path.
      if (out_xfer && s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (in_xfer) begin
        if (!m_valid || out_xfer) begin
          m_q     <= dec_c;
          m_valid <= 1'b1;
        end else begin
          s_q     <= dec_c;
          s_valid <= 1'b1;
        end
      end else if (out_xfer) begin
        m_valid <= 1'b0;
      end
    end else begin
      if (in_xfer) begin
        m_q     <= dec_c;
        m_valid <= 1'b1;
      end else if (out_xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign out_valid = m_valid;
  assign op        = m_q.op;
  assign rs_addr   = m_q.rs;
  assign rt_addr   = m_q.rt;
  assign rd_addr   = m_q.rd;
  assign shamt     = m_q.shamt;
  assign aluop     = m_q.aluop;
  assign imm_ext   = m_q.imm_ext;
  assign addr      = m_q.addr;
  assign pc        = m_q.pc;
  assign ins_class = m_q.cls;
  assign wb_en     = m_q.wb_en;
  assign wb_addr   = m_q.wb_addr;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (SKID=1 instance dut,
// SKID=0 instance dut0 used for the single-entry reset scenario).
module tb_decode_stage;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, rst_n0, flush, in_valid, out_ready;
  logic [31:0]   in_ins;
  logic [DW-1:0] in_pc;

  logic          in_ready, out_valid, wb_en;
  logic [5:0]    op, aluop;
  logic [4:0]    rs_addr, rt_addr, rd_addr, shamt, wb_addr;
  logic [DW-1:0] imm_ext, pc;
  logic [25:0]   addr;
  logic [1:0]    ins_class;

  logic          in_ready0, out_valid0, wb_en0;
  logic [5:0]    op0, aluop0;
  logic [4:0]    rs_addr0, rt_addr0, rd_addr0, shamt0, wb_addr0;
  logic [DW-1:0] imm_ext0, pc0;
  logic [25:0]   addr0;
  logic [1:0]    ins_class0;

  typedef struct packed {
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    aluop;
    logic [DW-1:0] imm;
    logic [25:0]   addr;
    logic [DW-1:0] pc;
    logic [1:0]    cls;
    logic          wb_en;
    logic [4:0]    wb_addr;
  } exp_t;

  exp_t act, act0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  assign act  = {op, rs_addr, rt_addr, rd_addr, shamt, aluop, imm_ext, addr, pc,
                 ins_class, wb_en, wb_addr};
  assign act0 = {op0, rs_addr0, rt_addr0, rd_addr0, shamt0, aluop0, imm_ext0, addr0, pc0,
                 ins_class0, wb_en0, wb_addr0};

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(DW), .LINK_REG(31), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .shamt(shamt),
    .aluop(aluop), .imm_ext(imm_ext), .addr(addr), .pc(pc), .ins_class(ins_class),
    .wb_en(wb_en), .wb_addr(wb_addr)
  );

  decode_stage #(.DATA_WIDTH(DW), .LINK_REG(31), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .op(op0), .rs_addr(rs_addr0), .rt_addr(rt_addr0), .rd_addr(rd_addr0), .shamt(shamt0),
    .aluop(aluop0), .imm_ext(imm_ext0), .addr(addr0), .pc(pc0), .ins_class(ins_class0),
    .wb_en(wb_en0), .wb_addr(wb_addr0)
  );

  // Reference decode of one instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic [DW-1:0] p);
    exp_t e;
    logic [5:0]  o;
    logic [15:0] im;
    o = ins[31:26];
    im = ins[15:0];
    e = '0;
    e.op = o; e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
    e.shamt = ins[10:6]; e.aluop = ins[5:0]; e.addr = ins[25:0]; e.pc = p;
    if (o == 6'h0C || o == 6'h0D || o == 6'h0E) e.imm = {16'h0000, im};
    else if (o == 6'h0F)                        e.imm = {im, 16'h0000};
    else                                        e.imm = {{16{im[15]}}, im};
    if (o == 6'h00) begin
      e.cls = 2'd0;
      e.wb_en = (ins[5:0] != 6'h08);
      e.wb_addr = e.wb_en ? ins[15:11] : 5'd0;
    end else if (o == 6'h02) begin
      e.cls = 2'd2;
    end else if (o == 6'h03) begin
      e.cls = 2'd2; e.wb_en = 1'b1; e.wb_addr = 5'd31;
    end else begin
      e.cls = 2'd1;
      e.wb_en = !(o == 6'h04 || o == 6'h05 || o == 6'h28 || o == 6'h2B);
      e.wb_addr = e.wb_en ? ins[20:16] : 5'd0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every output transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h with empty scoreboard", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_output: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted; expectation pushed on acceptance.
  task automatic send(input logic [31:0] ins, input logic [DW-1:0] p);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1; in_ins = ins; in_pc = p;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb.push_back(model(ins, p));
        done = 1;
      end
      tick();
      n++;
      if (!done && n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: ins %h not accepted, in_ready=%b", ins, in_ready);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still expected, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n0 = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b fields=%h required 0/0", out_valid, act);
    end
    checks++;
    if (out_valid0 !== 1'b0 || act0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs0: out_valid=%b fields=%h required 0/0", out_valid0, act0);
    end
    #2; rst_n = 1'b1; rst_n0 = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    send(32'h0022_1820, 32'h100);
    checks++;
    if (out_valid !== 1'b1 || rd_addr !== 5'd3 || pc !== 32'h100) begin
      errors++;
      $display("FAIL latency: out_valid=%b rd=%0d pc=%h required 1/3/100", out_valid, rd_addr, pc);
    end
    send(32'h3422_ABCD, 32'h104);
    send(32'h2022_FFFF, 32'h108);
    send(32'h3C01_1234, 32'h10C);
    send(32'h0C00_0010, 32'h110);
    send(32'h0800_0010, 32'h114);
    send(32'hAC22_0004, 32'h118);
    send(32'h03E0_0008, 32'h11C);
    send(32'h1022_FFFE, 32'h120);
    drain();
    // Spot-check a value from the plan independently of the model.
    checks++;
    if (model(32'h3C01_1234, 0).imm !== 32'h1234_0000) begin
      errors++;
      $display("FAIL lui_const: model gave %h required 12340000", model(32'h3C01_1234, 0).imm);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'h0022_1820; in_pc = 32'h200;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: in_ready=%b required 1", in_ready); end
    sb.push_back(model(32'h0022_1820, 32'h200));
    tick();
    in_ins = 32'h3422_ABCD; in_pc = 32'h204;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b: in_ready=%b required 1", in_ready); end
    sb.push_back(model(32'h3422_ABCD, 32'h204));
    tick();
    in_ins = 32'h2022_FFFF; in_pc = 32'h208;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: in_ready=%b required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || act !== model(32'h0022_1820, 32'h200)) begin
        errors++;
        $display("FAIL bp_hold: valid=%b got %h expected %h", out_valid, act, model(32'h0022_1820, 32'h200));
      end
      tick();
    end
    p0 = pops;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: in_ready=%b required 1", in_ready); end
    sb.push_back(model(32'h2022_FFFF, 32'h208));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    checks++;
    if (pops - p0 != 3) begin
      errors++;
      $display("FAIL bp_no_gap: %0d outputs in 3 cycles, required 3", pops - p0);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h0022_1820, 32'h300);
    send(32'h3422_ABCD, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_ins = 32'h2022_FFFF; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: out_valid=%b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: in_ready=%b required 1", in_ready); end
    out_ready = 1'b1;
    send(32'h3C01_1234, 32'h30C);
    drain();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_extra: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0022_1820, 32'h400);
    send(32'h0C00_0010, 32'h404);
    #2; rst_n = 1'b0; #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || act !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: out_valid=%b fields=%h required 0/0", out_valid, act);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: in_ready=%b required 1", in_ready); end
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(32'hAC22_0004, 32'h408);
    drain();
  endtask

  task automatic test_reset_mid_skid0();
    out_ready = 1'b0;
    #2; rst_n0 = 1'b0; #1; rst_n0 = 1'b1;
    tick();
    in_valid = 1'b1; in_ins = 32'h0022_1820; in_pc = 32'h500;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL s0_ready_empty: in_ready=%b required 1", in_ready0); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || act0 !== model(32'h0022_1820, 32'h500)) begin
      errors++;
      $display("FAIL s0_decode: valid=%b got %h expected %h", out_valid0, act0, model(32'h0022_1820, 32'h500));
    end
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("FAIL s0_ready_full: in_ready=%b required 0", in_ready0); end
    #2; rst_n0 = 1'b0; #1;
    checks++;
    if (out_valid0 !== 1'b0 || act0 !== '0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL s0_rst_mid: valid=%b fields=%h in_ready=%b required 0/0/1", out_valid0, act0, in_ready0);
    end
    rst_n0 = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_reset_mid_skid0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked instruction-decode pipeline stage for the MIPS-style core. It accepts one 32-bit instruction plus PC per cycle and splits it into register addresses, opcode/funct, shift amount, immediate and jump target. It also produces an extended immediate, instruction class and write-back target. It sits between fetch and register-read/execute, with valid/ready flow control on both sides, an optional skid buffer, and a synchronous flush for branch redirects.

## Interface
- `DATA_WIDTH`, 32: width of `imm_ext` and `pc`; must be ≥16.
- `LINK_REG`, 31: write-back register for `jal`.
- `SKID`, 1: 1 adds a second entry so `in_ready` is registered; 0 gives a single entry with `in_ready = !out_valid || out_ready`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: `in_ins`/`in_pc` are valid.
- `in_ready` out 1: stage accepts this cycle.
- `in_ins` in 32: instruction word.
- `in_pc` in DATA_WIDTH: instruction address.
- `out_valid` out 1: decoded fields are valid.
- `out_ready` in 1: downstream accepts.
- `op` out 6: `ins[31:26]`.
- `rs_addr`, `rt_addr`, `rd_addr` out 5 each: `ins[25:21]`, `ins[20:16]`, `ins[15:11]`.
- `shamt` out 5: `ins[10:6]`.
- `aluop` out 6: `ins[5:0]` (funct).
- `imm_ext` out DATA_WIDTH: extended `ins[15:0]`.
- `addr` out 26: `ins[25:0]`.
- `pc` out DATA_WIDTH: passthrough of `in_pc`.
- `ins_class` out 2: 0 = R, 1 = I, 2 = J.
- `wb_en` out 1: instruction writes a register.
- `wb_addr` out 5: destination register (0 when `wb_en`=0).

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Decode is combinational on `in_ins` and registered into the output entry. All outputs are registered.
- Class: op=0 → R. op=2 (j) or 3 (jal) → J. All other ops → I.
- `imm_ext`:
  - zero-extended for andi (0x0C), ori (0x0D), xori (0x0E);
  - lui (0x0F) gives `{imm,16'b0}` truncated/zero-padded to DATA_WIDTH;
  - all other ops are sign-extended.
- `wb_en` / `wb_addr`:
  - R: `rd`, except funct 0x08 (jr), where `wb_en`=0.
  - I: `rt`, except beq (0x04), bne (0x05), sb (0x28), sw (0x2B), where `wb_en`=0.
  - jal: `LINK_REG`. j: `wb_en`=0.
- SKID=1 storage: main entry M drives the outputs; skid entry S holds at most one instruction.
  - `in_ready` = !S.valid (registered).
  - On an input transfer: if M is empty or an output transfer occurs and S is empty, load M. Otherwise load S.
  - On an output transfer with S full, S moves to M and S clears.
- Order is always preserved. No instruction is dropped or duplicated without `flush`.
- `flush`: at the clock edge, clear M.valid and S.valid. An input presented in the flush cycle is discarded, even if `in_ready`=1. `in_ready`=1 in the following cycle.
- Reset: every output register is 0, `out_valid`=0, S empty, `in_ready`=1 after reset is released (SKID=1).

## Timing
- Latency is 1 cycle: an input accepted at edge N has `out_valid`=1 after edge N.
- Throughput is 1/cycle while `out_ready`=1.
- SKID=1: with `out_ready` low, exactly 2 instructions are absorbed. `in_ready` drops the cycle after the second accept.
- SKID=1: `in_ready` has no combinational path from `out_ready`.
- `flush` has priority over all transfers in the same cycle.
- Reset is asynchronous: asserting `rst_n` mid-stream clears both entries immediately, without waiting for a clock edge.
- Outputs hold stable while `out_valid && !out_ready`.

## Test plan
- R-type: `0x00221820`, pc `0x100` → op 0, rs 1, rt 2, rd 3, aluop `0x20`, class 0, wb_en 1, wb_addr 3, pc `0x100`, 1 cycle later.
- Extension: `0x3422ABCD` (ori) → imm_ext `0x0000ABCD`, wb_addr 2. `0x2022FFFF` (addi) → `0xFFFFFFFF`. `0x3C011234` (lui) → `0x12340000`.
- Jumps and stores: `0x0C000010` → class 2, addr `0x10`, wb_addr 31. `0x08000010` → wb_en 0. `0xAC220004` (sw) → wb_en 0, wb_addr 0.
- Backpressure (SKID=1): `out_ready`=0 and send A, B, C back-to-back → A and B accepted, `in_ready`=0 with C held. Then raise `out_ready` → output order A, B, C with no gaps and no loss.
- Flush: M and S full, assert `flush` for 1 cycle with `in_valid`=1 → `out_valid`=0 next cycle, the flush-cycle input is not seen, and the next input appears normally.
- Reset mid-operation: drop `rst_n` while `out_valid`=1 → all outputs 0 asynchronously, `in_ready`=1 after release; repeat with SKID=0.
